// File: rtl/clock_supervisor_if.sv
// rtl/clock_supervisor_if.sv - DCM supervisor lock/enable/status bundle
interface clock_supervisor_if #(
    parameter int Channels = 4,
    parameter int DivWidth = 8
);
    logic                         dcm_locked;
    logic [Channels*DivWidth-1:0] divisors;
    logic                         dcm_reset;
    logic                         sys_reset;
    logic                         ready;
    logic                         failed;
    logic [7:0]                   retry_count;
    logic [15:0]                  lock_losses;
    logic [Channels-1:0]          clock_en;

    // Supervisor side: consumes lock and divisors, drives resets, status and enables.
    modport slave (
        input  dcm_locked, divisors,
        output dcm_reset, sys_reset, ready, failed, retry_count, lock_losses, clock_en
    );

    // Environment side: the DCM and the divisor source.
    modport master (
        output dcm_locked, divisors,
        input  dcm_reset, sys_reset, ready, failed, retry_count, lock_losses, clock_en
    );
endinterface

// File: rtl/clock_supervisor.sv
// rtl/clock_supervisor.sv - DCM lock supervisor and clock-enable generator
module clock_supervisor #(
    parameter int Channels       = 4,
    parameter int DivWidth       = 8,
    parameter int DcmResetCycles = 4,
    parameter int LockTimeout    = 1000,
    parameter int StableCycles   = 16,
    parameter int MaxRetries     = 3
) (
    input  logic               clock,
    input  logic               reset,
    clock_supervisor_if.slave  bus
);

    typedef enum logic [2:0] {
        DCMRST   = 3'd0,
        WAITLOCK = 3'd1,
        STABLE   = 3'd2,
        RUN      = 3'd3,
        FAIL     = 3'd4
    } state_t;

    localparam logic [15:0] DcmRstLast = 16'(DcmResetCycles - 1);
    localparam logic [15:0] LockLast   = 16'(LockTimeout - 1);
    localparam logic [15:0] StableLast = 16'(StableCycles - 1);
    localparam logic [7:0]  RetryLimit = 8'(MaxRetries);

    state_t        state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [7:0]    retry_q, retry_d;
    logic [15:0]   losses_q, losses_d;
    logic [1:0]    sync_q;
    logic          locked_s;

    logic [DivWidth-1:0] cnt_q [Channels];
    logic [DivWidth-1:0] cnt_d [Channels];
    logic [DivWidth-1:0] div_q [Channels];
    logic [DivWidth-1:0] div_d [Channels];

    // Terminal count of a channel: divisors 0 and 1 both mean "every cycle".
    function automatic logic [DivWidth-1:0] last_of(input logic [DivWidth-1:0] d);
        return (d == '0) ? '0 : d - DivWidth'(1);
    endfunction

    assign locked_s = sync_q[1];

    // Two-flop synchronizer bringing the asynchronous LOCKED into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.dcm_locked};
        end
    end

    // Supervisor state, shared timer, retry and lock-loss counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= DCMRST;
            timer_q  <= '0;
            retry_q  <= '0;
            losses_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            losses_q <= losses_d;
        end
    end

    // Next-state logic; the timer restarts on every state change and idles in RUN/FAIL.
    always_comb begin
        state_d  = state_q;
        timer_d  = (state_q == RUN || state_q == FAIL) ? timer_q : timer_q + 16'd1;
        retry_d  = retry_q;
        losses_d = losses_q;
        case (state_q)
            DCMRST: begin
                if (timer_q == DcmRstLast) state_d = WAITLOCK;
            end
            WAITLOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (timer_q == LockLast) begin
                    if (retry_q == RetryLimit) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        state_d = DCMRST;
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAITLOCK;
                end else if (timer_q == StableLast) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    losses_d = (losses_q == 16'hFFFF) ? losses_q : losses_q + 16'd1;
                    retry_d  = '0;
                    state_d  = DCMRST;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = DCMRST;
            end
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    // Per-channel divider state; divisors are sampled at RUN entry and at each wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Channels; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    // Divider next state: counters sit at zero outside RUN so entry is phase-aligned.
    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            cnt_d[i] = '0;
            div_d[i] = div_q[i];
            if (state_q != RUN && state_d == RUN) begin
                div_d[i] = bus.divisors[i*DivWidth +: DivWidth];
            end else if (state_q == RUN && state_d == RUN) begin
                if (cnt_q[i] == last_of(div_q[i])) begin
                    div_d[i] = bus.divisors[i*DivWidth +: DivWidth];
                end else begin
                    cnt_d[i] = cnt_q[i] + DivWidth'(1);
                end
            end
        end
    end

    // Outputs decoded purely from registered state and counters.
    always_comb begin
        bus.dcm_reset   = (state_q == DCMRST);
        bus.sys_reset   = (state_q != RUN);
        bus.ready       = (state_q == RUN);
        bus.failed      = (state_q == FAIL);
        bus.retry_count = retry_q;
        bus.lock_losses = losses_q;
        bus.clock_en    = '0;
        for (int i = 0; i < Channels; i++) begin
            bus.clock_en[i] = (state_q == RUN) && (cnt_q[i] == '0);
        end
    end

endmodule

// File: doc/clock_supervisor.md
Name: clock_supervisor

Overview:
- Lock supervisor and clock-enable generator for the on-chip DCM.
- Sequences the DCM reset pulse and watches the asynchronous LOCKED signal. Holds system reset until lock has been stable for a set time, and retries or reports failure on timeout.
- Restarts the DCM automatically on loss of lock.
- Produces Channels independently divided clock enables in the DCM output domain, so slow logic avoids extra DCM taps and BUFGs.

Parameters:
- Channels, 4, number of clock-enable outputs.
- DivWidth, 8, width of each channel divisor.
- DcmResetCycles, 4, cycles dcm_reset is held high per attempt; minimum 3.
- LockTimeout, 1000, cycles to wait for lock before retrying; range 1..65535.
- StableCycles, 16, consecutive synchronized-lock cycles required before release; range 1..65535.
- MaxRetries, 3, retries allowed after the first attempt before declaring failure; range 0..255.

Ports:
- clock, in, 1, DCM output clock (CLK0 after BUFG).
- reset, in, 1, asynchronous, active-low.
- dcm_locked, in, 1, DCM LOCKED; asynchronous to clock.
- divisors, in, Channels*DivWidth, channel i divisor in bits [i*DivWidth +: DivWidth].
- dcm_reset, out, 1, DCM RST, active-high.
- sys_reset, out, 1, active-high reset to downstream logic.
- ready, out, 1, high only in RUN.
- failed, out, 1, high only in FAIL.
- retry_count, out, 8, retries used in the current acquisition.
- lock_losses, out, 16, count of RUN-state lock losses; saturates at 65535.
- clock_en, out, Channels, one-cycle enable pulses per channel.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - state = DCMRST, all counters = 0.
  - Output values: dcm_reset=1, sys_reset=1, ready=0, failed=0, clock_en=0, retry_count=0, lock_losses=0.
- Lock synchronizer:
  - Two flops, reset value 0. The internal signal locked_s lags dcm_locked by 2 edges.
  - The FSM uses only locked_s.
- Timer: a single shared 16-bit counter, cleared on every state transition.
- Outputs are decoded only from registered state and counters; no combinational path from any input.
- FSM states and transitions:
  - DCMRST: dcm_reset=1. When timer == DcmResetCycles-1, go to WAITLOCK. dcm_reset is high for exactly DcmResetCycles cycles.
  - WAITLOCK: dcm_reset=0.
    - If locked_s=1, go to STABLE.
    - Else if timer == LockTimeout-1: if retry_count == MaxRetries, go to FAIL; otherwise retry_count+1 and go to DCMRST.
    - locked_s has priority over the timeout in the same cycle.
  - STABLE:
    - If locked_s=0, go to WAITLOCK. The timeout restarts; retry_count is not incremented.
    - Else if timer == StableCycles-1, go to RUN.
  - RUN: sys_reset=0, ready=1.
    - If locked_s=0: lock_losses+1 (saturating), retry_count cleared, sys_reset=1 on the next edge, go to DCMRST.
  - FAIL: dcm_reset=0, sys_reset=1, failed=1. Terminal until reset.
- sys_reset is 1 in every state except RUN.
- Clock enables (per channel i):
  - Each channel has a DivWidth counter cnt_i and a latched divisor div_i.
  - Outside RUN: cnt_i=0, clock_en[i]=0.
  - In RUN: clock_en[i] = (cnt_i == 0).
  - cnt_i wraps to 0 when it reaches max(div_i,1)-1; otherwise it increments.
  - div_i is loaded from divisors on the RUN entry edge and on every wrap. A divisor change therefore takes effect at the next wrap, never mid-period.
  - Divisor 0 or 1 gives clock_en[i] high every RUN cycle.
  - Channels entering RUN together are phase-aligned: all pulse in the first RUN cycle.
- Timing from dcm_locked first sampled high at edge k (in WAITLOCK): STABLE after edge k+2, RUN (ready=1) after edge k+2+StableCycles.
- Reset mid-operation returns to DCMRST with lock_losses cleared.

Test Plan:
- Nominal acquisition (default parameters):
  - Stimulus: release reset; assert dcm_locked 10 cycles after dcm_reset falls.
  - Required: dcm_reset high exactly 4 cycles; ready/sys_reset change 18 edges after the lock edge; retry_count=0.
- Timeout and retry:
  - Stimulus: dcm_locked held 0.
  - Required: dcm_reset pulses 4 times (initial + 3 retries), 1004 cycles apart; failed=1 after the 4th timeout; retry_count=3; FAIL persists until reset.
- Glitch in STABLE:
  - Stimulus: dcm_locked drops for 3 cycles at cycle 8 of STABLE.
  - Required: return to WAITLOCK, no dcm_reset pulse, retry_count unchanged; ready only after a full 16 stable cycles.
- Loss in RUN:
  - Stimulus: deassert dcm_locked.
  - Required: ready=0 and sys_reset=1 three edges later; lock_losses=1; dcm_reset 4-cycle pulse; re-acquires with retry_count=0.
- Enables:
  - Stimulus: divisors = {0, 1, 3, 255}.
  - Required: ch0 and ch1 high every cycle; ch2 high every 3rd cycle; ch3 every 255th; all high in the first RUN cycle.
  - Stimulus: change ch2 to 5 mid-period.
  - Required: the current 3-cycle period completes, then 5-cycle spacing.
- Async reset:
  - Stimulus: assert reset in RUN, mid-period.
  - Required: all outputs take reset values immediately, before the next clock edge; lock_losses=0.
